// File: rtl/dot_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_update_scheduler_if
// Brief    : Processor update port, frame timing and dot-table write port.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_update_scheduler_if;
    logic       wr_en;
    logic [4:0] wr_dot;
    logic       wr_is_x;
    logic [9:0] wr_data;
    logic       wr_ready;
    logic       screen_end;
    logic       tbl_we;
    logic [4:0] tbl_dot;
    logic       tbl_is_x;
    logic [9:0] tbl_data;
    logic       frame_ready;
    logic [1:0] err;

    modport master (
        output wr_en, wr_dot, wr_is_x, wr_data, screen_end,
        input  wr_ready, tbl_we, tbl_dot, tbl_is_x, tbl_data, frame_ready, err
    );

    modport slave (
        input  wr_en, wr_dot, wr_is_x, wr_data, screen_end,
        output wr_ready, tbl_we, tbl_dot, tbl_is_x, tbl_data, frame_ready, err
    );
endinterface
`default_nettype wire

// File: rtl/dot_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dot_update_scheduler
// Brief    : Queues dot coordinate updates and commits them during the frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module dot_update_scheduler #(
    parameter int NUM_DOTS   = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    dot_update_scheduler_if.slave bus
);
    localparam int              c_aw       = $clog2(FIFO_DEPTH);
    localparam int              c_cw       = c_aw + 1;
    localparam logic [5:0]      c_num_dots = 6'(NUM_DOTS);
    localparam logic [9:0]      c_x_limit  = 10'd640;
    localparam logic [9:0]      c_y_limit  = 10'd480;
    localparam logic [c_cw-1:0] c_depth    = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one  = c_aw'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] r_snap_cnt;
    logic            r_prev_se;
    logic            r_tbl_we;
    logic [4:0]      r_tbl_dot;
    logic            r_tbl_is_x;
    logic [9:0]      r_tbl_data;
    logic [1:0]      r_err;

    logic            w_edge;
    logic            w_pop_fsm;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_wr_ready;
    logic            w_frame_ready;
    logic [15:0]     w_head;
    logic [4:0]      w_head_dot;
    logic            w_head_is_x;
    logic [9:0]      w_head_data;
    logic            w_head_ok;

    assign w_edge      = bus.screen_end & ~r_prev_se;
    assign w_full      = (r_count == c_depth);
    assign w_pop       = w_pop_fsm & ~reset;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_wr_ready  = ~reset & (~w_full | w_pop);
    assign w_push      = bus.wr_en & w_wr_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_dot  = w_head[15:11];
    assign w_head_is_x = w_head[10];
    assign w_head_data = w_head[9:0];
    assign w_head_ok   = ({1'b0, w_head_dot} < c_num_dots) &&
                         (w_head_is_x ? (w_head_data < c_x_limit)
                                      : (w_head_data < c_y_limit));

    // The first pop happens in the edge cycle so the registered table write
    // lands one cycle after the edge.
    always_comb begin
        w_state_next  = r_state;
        w_pop_fsm     = 1'b0;
        w_frame_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_pop_fsm    = (r_count != '0);
                    w_state_next = (r_count != '0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (!bus.screen_end) begin
                    w_state_next = ST_IDLE;
                end else if (r_snap_cnt != '0) begin
                    w_pop_fsm = 1'b1;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_frame_ready = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_prev_se  <= 1'b0;
            r_snap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_prev_se <= bus.screen_end;
            if (r_state == ST_IDLE && w_edge) begin
                r_snap_cnt <= r_count - {{c_aw{1'b0}}, w_pop};
            end else if (w_pop) begin
                r_snap_cnt <= r_snap_cnt - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.wr_dot, bus.wr_is_x, bus.wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tbl_we   <= 1'b0;
            r_tbl_dot  <= '0;
            r_tbl_is_x <= 1'b0;
            r_tbl_data <= '0;
            r_err      <= '0;
        end else begin
            r_tbl_we <= w_pop & w_head_ok;
            if (w_pop && w_head_ok) begin
                r_tbl_dot  <= w_head_dot;
                r_tbl_is_x <= w_head_is_x;
                r_tbl_data <= w_head_is_x ? w_head_data : {1'b0, w_head_data[8:0]};
            end
            if (bus.wr_en && !w_wr_ready) r_err[0] <= 1'b1;
            if (w_pop && !w_head_ok)      r_err[1] <= 1'b1;
        end
    end

    assign bus.wr_ready    = w_wr_ready;
    assign bus.tbl_we      = r_tbl_we & ~reset;
    assign bus.tbl_dot     = r_tbl_dot;
    assign bus.tbl_is_x    = r_tbl_is_x;
    assign bus.tbl_data    = r_tbl_data;
    assign bus.frame_ready = w_frame_ready & ~reset;
    assign bus.err         = r_err;

endmodule
`default_nettype wire
